// File: rtl/pd_packet_timer.sv
// Byte-position tracker for the packet decoder: counts accepted bytes against a
// selectable packet length, flags completion and aborts a packet that stalls.
module pd_packet_timer #(
    parameter int CNT_WIDTH = 7,
    parameter int SHORT_LEN = 62,
    parameter int LONG_LEN  = 111,
    parameter int TO_WIDTH  = 8,
    parameter int TIMEOUT   = 200
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 cnt_up,
    input  logic                 clr_cnt,
    input  logic                 len_sel,
    output logic [CNT_WIDTH-1:0] byte_count,
    output logic                 packet_done,
    output logic                 timeout,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] pkt_len
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] SHORT_L    = CNT_WIDTH'(SHORT_LEN);
    localparam logic [CNT_WIDTH-1:0] LONG_L     = CNT_WIDTH'(LONG_LEN);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO   = '0;
    localparam logic [TO_WIDTH-1:0]  STALL_LAST = TO_WIDTH'(TIMEOUT - 1);
    localparam logic [TO_WIDTH-1:0]  STALL_ONE  = TO_WIDTH'(1);

    state_t               state;
    state_t               state_nxt;
    logic [TO_WIDTH-1:0]  stall_cnt;
    logic [TO_WIDTH-1:0]  stall_nxt;
    logic [CNT_WIDTH-1:0] count_nxt;
    logic [CNT_WIDTH-1:0] len_nxt;
    logic                 done_nxt;
    logic                 timeout_nxt;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= IDLE;
            byte_count  <= '0;
            stall_cnt   <= '0;
            pkt_len     <= SHORT_L;
            packet_done <= 1'b0;
            timeout     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            byte_count  <= count_nxt;
            stall_cnt   <= stall_nxt;
            pkt_len     <= len_nxt;
            packet_done <= done_nxt;
            timeout     <= timeout_nxt;
            busy        <= (state_nxt != IDLE);
        end
    end

    // DONE behaves like IDLE for the next byte, which is what makes
    // back-to-back packets possible without an idle gap.
    always_comb begin
        state_nxt   = state;
        count_nxt   = byte_count;
        stall_nxt   = stall_cnt;
        len_nxt     = pkt_len;
        done_nxt    = 1'b0;
        timeout_nxt = 1'b0;

        if (clr_cnt) begin
            state_nxt = IDLE;
            count_nxt = CNT_ZERO;
            stall_nxt = '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    stall_nxt = '0;
                    if (cnt_up) begin
                        len_nxt   = len_sel ? LONG_L : SHORT_L;
                        count_nxt = CNT_ONE;
                        state_nxt = ACTIVE;
                    end else begin
                        count_nxt = CNT_ZERO;
                        state_nxt = IDLE;
                    end
                end
                ACTIVE: begin
                    if (cnt_up) begin
                        count_nxt = byte_count + CNT_ONE;
                        stall_nxt = '0;
                        if ((byte_count + CNT_ONE) == pkt_len) begin
                            state_nxt = DONE;
                            done_nxt  = 1'b1;
                        end
                    end else if (stall_cnt == STALL_LAST) begin
                        state_nxt   = IDLE;
                        count_nxt   = CNT_ZERO;
                        stall_nxt   = '0;
                        timeout_nxt = 1'b1;
                    end else begin
                        stall_nxt = stall_cnt + STALL_ONE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    count_nxt = CNT_ZERO;
                    stall_nxt = '0;
                end
            endcase
        end
    end

endmodule

// File: doc/pd_packet_timer.md
# pd_packet_timer

Parametrised byte-position tracker for the packet decoder. Counts accepted bytes of the current packet against one of two selectable packet lengths. Issues a one-cycle `packet_done` on the final byte and a one-cycle `timeout` when the byte stream stalls mid-packet. Sits between the decoder control FSM (which drives `cnt_up`/`clr_cnt`) and the header/nonce field extractors (which consume `byte_count`).

## Interface
- `CNT_WIDTH`, 7: width of `byte_count`.
- `SHORT_LEN`, 62: packet length in bytes when `len_sel`=0. Range 2..2^CNT_WIDTH-1.
- `LONG_LEN`, 111: packet length in bytes when `len_sel`=1. Same range as `SHORT_LEN`.
- `TO_WIDTH`, 8: width of the internal stall counter.
- `TIMEOUT`, 200: consecutive stalled ACTIVE cycles before abort. Range 1..2^TO_WIDTH-1.
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `n_rst`, in, 1: asynchronous active-low reset.
- `cnt_up`, in, 1: one byte accepted this cycle.
- `clr_cnt`, in, 1: synchronous abort/clear. Highest priority.
- `len_sel`, in, 1: length select, sampled only on the first byte of a packet.
- `byte_count`, out, CNT_WIDTH: bytes accepted in the current packet.
- `packet_done`, out, 1: one-cycle pulse, final byte reached.
- `timeout`, out, 1: one-cycle pulse, packet aborted due to stall.
- `busy`, out, 1: high in ACTIVE and DONE.
- `pkt_len`, out, CNT_WIDTH: latched target length of the current or last packet.

## Operation
- States: IDLE, ACTIVE, DONE. All outputs are registered.
- Reset values: state IDLE; `byte_count`=0; `packet_done`=0; `timeout`=0; `busy`=0; `pkt_len`=`SHORT_LEN`; stall counter 0.
- `clr_cnt`=1, any state:
  - next state IDLE; `byte_count`=0; stall counter 0.
  - No `packet_done` or `timeout` is generated for that cycle, even if `cnt_up` is also 1. `pkt_len` holds.
- IDLE:
  - `cnt_up`=1: latch `pkt_len` from `len_sel` (0 → `SHORT_LEN`, 1 → `LONG_LEN`); `byte_count`←1; stall counter←0; go to ACTIVE.
  - Otherwise hold; `byte_count` stays 0.
- ACTIVE with `cnt_up`=1:
  - `byte_count`←`byte_count`+1; stall counter←0.
  - If `byte_count`+1 == `pkt_len`: go to DONE and set `packet_done`←1.
- ACTIVE with `cnt_up`=0:
  - Stall counter increments.
  - If the stall counter == `TIMEOUT`-1: go to IDLE; `byte_count`←0; `timeout`←1.
- DONE (lasts exactly one cycle):
  - `byte_count` == `pkt_len`; `packet_done`=1.
  - `cnt_up`=1 starts the next packet back-to-back: re-latch `len_sel`, `byte_count`←1, go to ACTIVE.
  - Otherwise go to IDLE with `byte_count`←0.
- `len_sel` changes while ACTIVE have no effect.
- `byte_count` never exceeds `pkt_len`, so no wrap-around can occur.

## Timing
- `byte_count` updates one cycle after the `cnt_up` edge that is sampled.
- `packet_done` is high in exactly the cycle where `byte_count` == `pkt_len`. It is never high for two consecutive cycles.
- Timeout latency: with the last `cnt_up` sampled at edge t, and no `cnt_up` and no `clr_cnt` at edges t+1 .. t+`TIMEOUT`, `timeout` is high for one cycle after edge t+`TIMEOUT` with `byte_count`=0.
- A `cnt_up` at edge t+`TIMEOUT` prevents the timeout and resets the stall window.
- `timeout` and `packet_done` are mutually exclusive.
- `busy` rises one cycle after the first `cnt_up`. It falls one cycle after DONE or timeout when no new byte arrives.
- Asserting `n_rst` mid-packet forces all outputs to their reset values immediately (asynchronously). The count restarts from 0 after release.

## Test plan
- Reset, `len_sel`=0, 62 consecutive `cnt_up` pulses → `byte_count` steps 1..62; `packet_done`=1 only in the cycle `byte_count`=62; `byte_count`=0 next cycle.
- `len_sel`=1 on the first byte, toggled mid-packet, 111 bytes with random gaps shorter than 200 cycles → `pkt_len`=111; `packet_done` only at `byte_count`=111.
- Back-to-back: `cnt_up` held high for 62+111 cycles, `len_sel`=0 then 1 at the packet boundary → two `packet_done` pulses 111 cycles apart; count goes 62 → 1 with no IDLE cycle.
- Stall: 10 bytes, then `cnt_up` low for 200 cycles → `timeout`=1 for one cycle exactly 200 edges after the last byte; `byte_count`=0; `busy`=0. A repeat with a byte at edge 200 → no timeout.
- `clr_cnt` with `cnt_up` at `byte_count`=61 (SHORT) → `byte_count`=0, no `packet_done`, no `timeout`, state IDLE.
- `n_rst` pulse at `byte_count`=50 → all outputs 0 (`pkt_len`=62) immediately; a new packet counts from 1 after release.
